// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface memory_stage_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // Pipeline side issues requests.
   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   // Memory side answers them.
   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit pipeline: LOAD/STORE over a req/ack bus with a timeout,
// single-cycle pass-through for every other instruction.
module memory_stage #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        control_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [4:0]        dest_index_in,
   input  logic              reg_we_in,
   output logic              stall_out,
   memory_stage_if.master    mem,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        wb_control,
   output logic              mem_err
);

   localparam logic [3:0] OP_LOAD  = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1110;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [4:0]        dest_q, dest_d;
   logic              rwe_q, rwe_d;
   logic [3:0]        ctrl_q, ctrl_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [3:0]        wb_ctrl_q, wb_ctrl_d;
   logic              err_q, err_d;

   logic is_mem;
   logic at_limit;

   assign is_mem   = (control_in == OP_LOAD) || (control_in == OP_STORE);
   assign at_limit = (cnt_q == CNT_LAST);

   // Hold upstream while an access is being issued or is still within its wait budget.
   always_comb begin
      stall_out = ((state_q == StIdle) && is_mem) ||
                  ((state_q == StWait) && !mem.mem_ack && (cnt_q < CNT_LAST));
   end

   // Next-state and output bundle for the IDLE/WAIT access machine.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      dest_d     = dest_q;
      rwe_d      = rwe_q;
      ctrl_d     = ctrl_q;
      wb_valid_d = 1'b0;
      wb_we_d    = wb_we_q;
      wb_dest_d  = wb_dest_q;
      wb_data_d  = wb_data_q;
      wb_ctrl_d  = wb_ctrl_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (is_mem) begin
               addr_d  = result_in[ADDR_W-1:0];
               wdata_d = store_data_in;
               we_d    = (control_in == OP_STORE);
               dest_d  = dest_index_in;
               rwe_d   = reg_we_in;
               ctrl_d  = control_in;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = StWait;
            end else begin
               wb_valid_d = 1'b1;
               wb_we_d    = reg_we_in;
               wb_dest_d  = dest_index_in;
               wb_data_d  = result_in;
               wb_ctrl_d  = control_in;
            end
         end
         StWait: begin
            // Ack wins over abort when both land on the last budget cycle.
            if (mem.mem_ack) begin
               req_d      = 1'b0;
               state_d    = StIdle;
               wb_valid_d = 1'b1;
               wb_dest_d  = dest_q;
               wb_ctrl_d  = ctrl_q;
               if (ctrl_q == OP_LOAD) begin
                  wb_we_d   = rwe_q;
                  wb_data_d = mem.mem_rdata;
               end else begin
                  wb_we_d   = 1'b0;
                  wb_data_d = DATA_W'(addr_q);
               end
            end else if (at_limit) begin
               req_d      = 1'b0;
               err_d      = 1'b1;
               state_d    = StIdle;
               wb_valid_d = 1'b1;
               wb_we_d    = 1'b0;
               wb_dest_d  = dest_q;
               wb_data_d  = '0;
               wb_ctrl_d  = ctrl_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; reset discards any pending access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         dest_q     <= '0;
         rwe_q      <= 1'b0;
         ctrl_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_dest_q  <= '0;
         wb_data_q  <= '0;
         wb_ctrl_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         dest_q     <= dest_d;
         rwe_q      <= rwe_d;
         ctrl_q     <= ctrl_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_dest_q  <= wb_dest_d;
         wb_data_q  <= wb_data_d;
         wb_ctrl_q  <= wb_ctrl_d;
         err_q      <= err_d;
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign wb_valid      = wb_valid_q;
   assign wb_we         = wb_we_q;
   assign wb_dest       = wb_dest_q;
   assign wb_data       = wb_data_q;
   assign wb_control    = wb_ctrl_q;
   assign mem_err       = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: driver pushes expected writebacks, a memory
// responder answers requests, a monitor pops and compares every valid writeback.
module tb_memory_stage;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;
   localparam logic [3:0] OP_LOAD  = 4'b1100;
   localparam logic [3:0] OP_STORE = 4'b1110;
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]        control_in;
   logic [DATA_W-1:0] result_in, store_data_in;
   logic [4:0]        dest_index_in;
   logic              reg_we_in;
   logic              stall_out;
   logic              wb_valid, wb_we, mem_err;
   logic [4:0]        wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        wb_control;

   memory_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

   memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .control_in    (control_in),
      .result_in     (result_in),
      .store_data_in (store_data_in),
      .dest_index_in (dest_index_in),
      .reg_we_in     (reg_we_in),
      .stall_out     (stall_out),
      .mem           (mem_bus),
      .wb_valid      (wb_valid),
      .wb_we         (wb_we),
      .wb_dest       (wb_dest),
      .wb_data       (wb_data),
      .wb_control    (wb_control),
      .mem_err       (mem_err)
   );

   typedef struct {
      logic        we;
      logic [4:0]  dest;
      logic [15:0] data;
      logic [3:0]  ctrl;
      logic        err;
   } wb_t;

   typedef struct {
      int          lat;
      bit          ack_en;
      logic [15:0] rdata;
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } acc_t;

   wb_t  sb[$];
   acc_t acc_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   bit   err_model = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one op; returns how many cycles stall_out held it.
   task automatic do_op(input logic [3:0] ctrl, input logic [15:0] res, input logic [15:0] sd,
                        input logic [4:0] dest, input logic we, input int lat,
                        input bit ack_en, input logic [15:0] rdata, output int stalls);
      wb_t  e;
      acc_t a;
      bit   done;
      @(negedge clk);
      control_in    = ctrl;
      result_in     = res;
      store_data_in = sd;
      dest_index_in = dest;
      reg_we_in     = we;
      stalls        = 0;
      e.dest        = dest;
      if (ctrl == OP_LOAD || ctrl == OP_STORE) begin
         a.lat = lat; a.ack_en = ack_en; a.rdata = rdata;
         a.addr = res; a.we = (ctrl == OP_STORE); a.wdata = sd;
         acc_q.push_back(a);
         if (ack_en && lat <= TIMEOUT - 1) begin
            e.ctrl = ctrl;
            if (ctrl == OP_LOAD) begin e.we = we; e.data = rdata; end
            else begin e.we = 1'b0; e.data = res; end
         end else begin
            err_model = 1'b1;
            e.we = 1'b0; e.data = 16'h0000; e.ctrl = ctrl;
         end
      end else begin
         e.we = we; e.data = res; e.ctrl = ctrl;
      end
      e.err = err_model;
      sb.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         #2;
         if (!stall_out) begin
            done = 1'b1;
            break;
         end
         stalls++;
         @(negedge clk);
      end
      if (!done) chk("stall_release_timeout", 32'(stalls), 32'(0));
   endtask

   // Memory model: answers each request after its scheduled latency.
   initial begin : responder
      acc_t a;
      int   wc;
      bit   stable;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && mem_bus.mem_req === 1'b1) begin
            if (acc_q.size() == 0) begin
               chk("unexpected_mem_req", 32'(mem_bus.mem_req), 32'(0));
               @(negedge clk);
            end else begin
               a = acc_q.pop_front();
               chk("mem_addr", 32'(mem_bus.mem_addr), 32'(a.addr));
               chk("mem_we", 32'(mem_bus.mem_we), 32'(a.we));
               if (a.we) chk("mem_wdata", 32'(mem_bus.mem_wdata), 32'(a.wdata));
               wc = 0;
               stable = 1'b1;
               for (int k = 0; k < 40; k++) begin
                  if (k > 0) @(negedge clk);
                  if (a.ack_en && k == a.lat) begin
                     mem_bus.mem_ack   = 1'b1;
                     mem_bus.mem_rdata = a.rdata;
                     @(negedge clk);
                     mem_bus.mem_ack   = 1'b0;
                     mem_bus.mem_rdata = 16'($urandom);
                     chk("req_drop_after_ack", 32'(mem_bus.mem_req), 32'(0));
                     break;
                  end
                  if (mem_bus.mem_req) begin
                     wc++;
                     if (mem_bus.mem_addr !== a.addr || mem_bus.mem_we !== a.we ||
                         (a.we && mem_bus.mem_wdata !== a.wdata)) stable = 1'b0;
                  end else if (!a.ack_en) begin
                     break;
                  end
               end
               chk("req_stable", 32'(stable), 32'(1));
               if (!a.ack_en) chk("timeout_wait_cycles", 32'(wc), 32'(TIMEOUT));
            end
         end
      end
   end

   // Monitor: every valid writeback must match the oldest expectation.
   always @(negedge clk) begin
      wb_t e;
      if (mon_en && rst_n === 1'b1 && wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_wb", 32'(wb_valid), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("wb_we", 32'(wb_we), 32'(e.we));
            chk("wb_dest", 32'(wb_dest), 32'(e.dest));
            chk("wb_data", 32'(wb_data), 32'(e.data));
            chk("wb_control", 32'(wb_control), 32'(e.ctrl));
            chk("mem_err", 32'(mem_err), 32'(e.err));
         end
      end
   end

   initial begin : main
      int          st;
      logic [3:0]  c;
      int          r, lat;
      bit          ack_en, saw_load;
      int          req_seen;
      control_in = OP_NOP; result_in = '0; store_data_in = '0;
      dest_index_in = '0; reg_we_in = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wb_valid", 32'(wb_valid), 32'(0));
      chk("rst_mem_req", 32'(mem_bus.mem_req), 32'(0));
      chk("rst_mem_err", 32'(mem_err), 32'(0));
      chk("rst_wb_data", 32'(wb_data), 32'(0));
      chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'(0));
      chk("rst_stall", 32'(stall_out), 32'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;

      do_op(OP_ADD, 16'h0042, 16'h0, 5'd3, 1'b1, 0, 1'b0, 16'h0, st);
      chk("t1_stall_cycles", 32'(st), 32'(0));
      do_op(OP_LOAD, 16'h0010, 16'h0, 5'd5, 1'b1, 3, 1'b1, 16'hBEEF, st);
      chk("t2_stall_cycles", 32'(st), 32'(4));
      do_op(OP_STORE, 16'h0020, 16'h1234, 5'd6, 1'b1, 0, 1'b1, 16'h0, st);
      chk("t3_stall_cycles", 32'(st), 32'(1));
      do_op(OP_LOAD, 16'h0030, 16'h0, 5'd7, 1'b1, 0, 1'b0, 16'h0, st);
      chk("t4_stall_cycles", 32'(st), 32'(TIMEOUT));
      do_op(OP_ADD, 16'h0077, 16'h0, 5'd8, 1'b1, 0, 1'b0, 16'h0, st);
      chk("t4_add_stall", 32'(st), 32'(0));
      do_op(OP_LOAD, 16'h0050, 16'h0, 5'd10, 1'b1, 1, 1'b1, 16'hA5A5, st);
      do_op(OP_STORE, 16'h0060, 16'h5A5A, 5'd11, 1'b1, 1, 1'b1, 16'h0, st);
      chk("t5_store_stall", 32'(st), 32'(2));
      // Ack landing exactly on the last budget cycle is a success.
      do_op(OP_LOAD, 16'h0070, 16'h0, 5'd12, 1'b1, TIMEOUT - 1, 1'b1, 16'hC0DE, st);
      chk("ack_on_limit_stall", 32'(st), 32'(TIMEOUT));
      do_op(OP_NOP, 16'h0001, 16'h0, 5'd0, 1'b0, 0, 1'b0, 16'h0, st);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         ack_en = ($urandom_range(0, 9) != 0);
         lat = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 6);
         if (r < 4) begin
            c = 4'($urandom_range(0, 15));
            while (c == OP_LOAD || c == OP_STORE) c = 4'($urandom_range(0, 15));
         end else if (r < 7) begin
            c = OP_LOAD;
         end else begin
            c = OP_STORE;
         end
         do_op(c, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), lat, ack_en,
               16'($urandom), st);
      end
      do_op(OP_NOP, 16'h0000, 16'h0, 5'd0, 1'b0, 0, 1'b0, 16'h0, st);

      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      mon_en = 1'b0;
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));
      chk("accesses_drained", 32'(acc_q.size()), 32'(0));

      // Reset in the middle of an access; the late ack must be ignored.
      @(negedge clk);
      control_in = OP_LOAD; result_in = 16'h0040; dest_index_in = 5'd9; reg_we_in = 1'b1;
      acc_q.push_back('{lat: 5, ack_en: 1'b1, rdata: 16'hDEAD, addr: 16'h0040, we: 1'b0,
                        wdata: 16'h0});
      @(negedge clk);
      chk("t6_req_before_reset", 32'(mem_bus.mem_req), 32'(1));
      @(negedge clk);
      #1 rst_n = 1'b0;
      control_in = OP_NOP;
      #1;
      chk("t6_mem_req", 32'(mem_bus.mem_req), 32'(0));
      chk("t6_wb_valid", 32'(wb_valid), 32'(0));
      chk("t6_mem_err", 32'(mem_err), 32'(0));
      chk("t6_mem_addr", 32'(mem_bus.mem_addr), 32'(0));
      chk("t6_wb_data", 32'(wb_data), 32'(0));
      chk("t6_wb_we", 32'(wb_we), 32'(0));
      chk("t6_stall", 32'(stall_out), 32'(0));
      @(negedge clk);
      #1 rst_n = 1'b1;
      err_model = 1'b0;
      saw_load = 1'b0;
      req_seen = 0;
      repeat (7) begin
         @(negedge clk);
         if (mem_bus.mem_req) req_seen++;
         if (wb_valid && wb_control == OP_LOAD) saw_load = 1'b1;
      end
      chk("t6_req_after_reset", 32'(req_seen), 32'(0));
      chk("t6_no_load_wb", 32'(saw_load), 32'(0));
      chk("t6_err_after_reset", 32'(mem_err), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
